// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-lock controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    localparam int unsigned KEY_ENTER   = 0;
    localparam int unsigned KEY_ADMIN   = 8;
    localparam int unsigned KEY_CLEAR   = 12;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

    // Returns {valid, bcd}; valid is set only for the ten digit keys.
    function automatic logic [4:0] key_to_bcd(input logic [15:0] key);
        logic [4:0] res;
        res = 5'b0;
        case (key)
            16'h0008: res = {1'b1, 4'd0};
            16'h0080: res = {1'b1, 4'd1};
            16'h0040: res = {1'b1, 4'd2};
            16'h0020: res = {1'b1, 4'd3};
            16'h0800: res = {1'b1, 4'd4};
            16'h0400: res = {1'b1, 4'd5};
            16'h0200: res = {1'b1, 4'd6};
            16'h8000: res = {1'b1, 4'd7};
            16'h4000: res = {1'b1, 4'd8};
            16'h2000: res = {1'b1, 4'd9};
            default:  res = 5'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/beep_gen.sv
// Buzzer pattern generator: square wave of half-period TONE_DIV for a loaded
// number of cycles, built from two down-counters with terminal-count compare.
module beep_gen #(
    parameter int unsigned TONE_DIV = 50000,
    parameter int unsigned DUR_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DUR_W-1:0] dur,
    input  logic             stop,
    output logic             buzzer,
    output logic             active
);

    localparam int unsigned      TONE_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TONE_W-1:0] TONE_LOAD = TONE_W'(TONE_DIV - 1);

    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              buzzer_q, buzzer_d;
    logic              active_q, active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_q    <= '0;
            tone_q   <= '0;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            dur_q    <= dur_d;
            tone_q   <= tone_d;
            buzzer_q <= buzzer_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        dur_d    = dur_q;
        tone_d   = tone_q;
        buzzer_d = buzzer_q;
        active_d = active_q;
        if (stop) begin
            dur_d    = '0;
            tone_d   = '0;
            buzzer_d = 1'b0;
            active_d = 1'b0;
        end else if (start) begin
            dur_d    = dur;
            tone_d   = TONE_LOAD;
            buzzer_d = 1'b1;
            active_d = 1'b1;
        end else if (active_q) begin
            // dur_q==1 marks the last cycle of the beep
            if (dur_q == DUR_W'(1)) begin
                dur_d    = '0;
                tone_d   = '0;
                buzzer_d = 1'b0;
                active_d = 1'b0;
            end else begin
                dur_d = dur_q - DUR_W'(1);
                if (tone_q == '0) begin
                    tone_d   = TONE_LOAD;
                    buzzer_d = ~buzzer_q;
                end else begin
                    tone_d = tone_q - TONE_W'(1);
                end
            end
        end
    end

    assign buzzer = buzzer_q;
    assign active = active_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: assembles a BCD code from key presses, checks it on ENTER,
// counts failures up to lockout and drives key-click / fail buzzer patterns.
//
//   state    | meaning
//   ENTRY    | collecting digits, ENTER compares against PASSWORD
//   UNLOCKED | code accepted, display shows PASS_GLYPH, CLEAR relocks
//   LOCKOUT  | too many failures, only ADMIN is honoured
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned         DIGITS           = 3,
    parameter logic [4*DIGITS-1:0] PASSWORD         = 12'h246,
    parameter int unsigned         MAX_TRIES        = 6,
    parameter int unsigned         TONE_DIV         = 50000,
    parameter int unsigned         KEY_BEEP_CYCLES  = 2_000_000,
    parameter int unsigned         FAIL_BEEP_CYCLES = 10_000_000,
    parameter logic [3:0]          PASS_GLYPH       = 4'hA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           key_onehot,
    output logic [4*DIGITS-1:0]   disp,
    output logic [3:0]            entry_cnt,
    output logic [3:0]            tries,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic                  buzzer
);

    localparam int unsigned MAX_BEEP = (KEY_BEEP_CYCLES > FAIL_BEEP_CYCLES) ?
                                       KEY_BEEP_CYCLES : FAIL_BEEP_CYCLES;
    localparam int unsigned DUR_W    = $clog2(MAX_BEEP + 1);

    localparam logic [DUR_W-1:0]    KEY_DUR   = DUR_W'(KEY_BEEP_CYCLES);
    localparam logic [DUR_W-1:0]    FAIL_DUR  = DUR_W'(FAIL_BEEP_CYCLES);
    localparam logic [3:0]          DIGITS_N  = 4'(DIGITS);
    localparam logic [3:0]          TRIES_MAX = 4'(MAX_TRIES);
    localparam logic [4*DIGITS-1:0] BLANK_ALL = {DIGITS{BLANK_DIGIT}};
    localparam logic [4*DIGITS-1:0] GLYPH_ALL = {DIGITS{PASS_GLYPH}};

    lock_state_t         state_q, state_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          tries_q, tries_d;
    logic [15:0]         prev_key_q;
    logic                fail_q, fail_d;

    logic       key_single, press;
    logic [4:0] dec;
    logic [3:0] tries_inc;
    logic       key_beep, fail_beep, beep_stop, beep_start, beep_active;
    logic [DUR_W-1:0] beep_dur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ENTRY;
            disp_q     <= BLANK_ALL;
            cnt_q      <= '0;
            tries_q    <= '0;
            prev_key_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            prev_key_q <= key_onehot;
            fail_q     <= fail_d;
        end
    end

    // A press is a clean one-hot vector following an all-released sample.
    assign key_single = (key_onehot != '0) && ((key_onehot & (key_onehot - 16'd1)) == '0);
    assign press      = key_single && (prev_key_q == '0);
    assign dec        = key_to_bcd(key_onehot);
    assign tries_inc  = (tries_q < TRIES_MAX) ? tries_q + 4'd1 : tries_q;

    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        key_beep  = 1'b0;
        fail_beep = 1'b0;
        beep_stop = 1'b0;
        if (press) begin
            if (key_onehot[KEY_ADMIN]) begin
                state_d   = ENTRY;
                disp_d    = BLANK_ALL;
                cnt_d     = '0;
                tries_d   = '0;
                beep_stop = 1'b1;
            end else begin
                case (state_q)
                    ENTRY: begin
                        if (dec[4]) begin
                            if (cnt_q < DIGITS_N) begin
                                disp_d      = disp_q << 4;
                                disp_d[3:0] = dec[3:0];
                                cnt_d       = cnt_q + 4'd1;
                                key_beep    = 1'b1;
                            end
                        end else if (key_onehot[KEY_ENTER] && (cnt_q == DIGITS_N)) begin
                            if (disp_q == PASSWORD) begin
                                state_d  = UNLOCKED;
                                disp_d   = GLYPH_ALL;
                                tries_d  = '0;
                                key_beep = 1'b1;
                            end else begin
                                disp_d    = BLANK_ALL;
                                cnt_d     = '0;
                                tries_d   = tries_inc;
                                fail_beep = 1'b1;
                                if (tries_inc == TRIES_MAX) begin
                                    state_d = LOCKOUT;
                                    disp_d  = '0;
                                end
                            end
                        end else if (key_onehot[KEY_CLEAR]) begin
                            disp_d = BLANK_ALL;
                            cnt_d  = '0;
                        end
                    end
                    UNLOCKED: begin
                        if (key_onehot[KEY_CLEAR]) begin
                            state_d = ENTRY;
                            disp_d  = BLANK_ALL;
                            cnt_d   = '0;
                        end
                    end
                    LOCKOUT: begin
                    end
                    default: state_d = ENTRY;
                endcase
            end
        end
    end

    // A running fail beep swallows key-click requests instead of being cut short.
    always_comb begin
        beep_start = fail_beep || (key_beep && !(fail_q && beep_active));
        beep_dur   = fail_beep ? FAIL_DUR : KEY_DUR;
        fail_d     = fail_q;
        if (beep_stop) begin
            fail_d = 1'b0;
        end else if (fail_beep) begin
            fail_d = 1'b1;
        end else if (beep_start) begin
            fail_d = 1'b0;
        end
    end

    beep_gen #(
        .TONE_DIV (TONE_DIV),
        .DUR_W    (DUR_W)
    ) u_beep (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (beep_start),
        .dur    (beep_dur),
        .stop   (beep_stop),
        .buzzer (buzzer),
        .active (beep_active)
    );

    assign disp       = disp_q;
    assign entry_cnt  = cnt_q;
    assign tries      = tries_q;
    assign unlocked   = (state_q == UNLOCKED);
    assign locked_out = (state_q == LOCKOUT);

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboarded bench for keypad_lock_ctrl: a behavioural lock model predicts every
// post-edge output; a monitor process pops and compares each cycle.
module tb_keypad_lock_ctrl;

    localparam int          DIGITS    = 3;
    localparam logic [11:0] PASSWORD  = 12'h246;
    localparam int          MAX_TRIES = 6;
    localparam int          TONE      = 4;
    localparam int          KEYB      = 20;
    localparam int          FAILB     = 50;

    localparam logic [15:0] K_ENTER = 16'h0001;
    localparam logic [15:0] K_ADMIN = 16'h0100;
    localparam logic [15:0] K_CLEAR = 16'h1000;

    logic        clk, rst_n;
    logic [15:0] key_onehot;
    logic [11:0] disp;
    logic [3:0]  entry_cnt, tries;
    logic        unlocked, locked_out, buzzer;

    keypad_lock_ctrl #(
        .DIGITS           (DIGITS),
        .PASSWORD         (PASSWORD),
        .MAX_TRIES        (MAX_TRIES),
        .TONE_DIV         (TONE),
        .KEY_BEEP_CYCLES  (KEYB),
        .FAIL_BEEP_CYCLES (FAILB),
        .PASS_GLYPH       (4'hA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_onehot (key_onehot),
        .disp       (disp),
        .entry_cnt  (entry_cnt),
        .tries      (tries),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .buzzer     (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          cyc;
        logic [11:0] disp;
        logic [3:0]  cnt;
        logic [3:0]  tries;
        logic        unl;
        logic        lo;
        logic        buz;
    } exp_t;
    exp_t sbq[$];

    int bit_of_digit [10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};

    // Reference model: mode 0 = entering, 1 = open, 2 = locked out.
    int          m_mode;
    int          m_dig[$];
    int          m_tries;
    logic [15:0] m_prev;
    int          b_start, b_len;
    bit          b_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] dkey(input int d);
        return 16'h1 << bit_of_digit[d];
    endfunction

    function automatic int digit_of_key(input logic [15:0] k);
        for (int d = 0; d < 10; d++)
            if (k == (16'h1 << bit_of_digit[d])) return d;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_dig.delete();
        m_tries = 0;
        m_prev = '0;
        b_start = 0;
        b_len = 0;
        b_fail = 0;
    endtask

    task automatic model_step(input logic [15:0] k);
        int   e, d, code, bt;
        bit   ev, kb, fb;
        exp_t x;
        e  = cyc + 1;
        ev = ($countones(k) == 1) && (m_prev == '0);
        m_prev = k;
        kb = 0;
        fb = 0;
        if (ev) begin
            d = digit_of_key(k);
            if (k == K_ADMIN) begin
                m_mode = 0;
                m_dig.delete();
                m_tries = 0;
                b_len = 0;
                b_fail = 0;
            end else if (m_mode == 0) begin
                if (d >= 0) begin
                    if (m_dig.size() < DIGITS) begin
                        m_dig.push_back(d);
                        kb = 1;
                    end
                end else if (k == K_ENTER && m_dig.size() == DIGITS) begin
                    code = 0;
                    foreach (m_dig[i]) code = code * 16 + m_dig[i];
                    if (code == int'(PASSWORD)) begin
                        m_mode = 1;
                        m_tries = 0;
                        kb = 1;
                    end else begin
                        m_tries++;
                        m_dig.delete();
                        fb = 1;
                        if (m_tries == MAX_TRIES) m_mode = 2;
                    end
                end else if (k == K_CLEAR) begin
                    m_dig.delete();
                end
            end else if (m_mode == 1) begin
                if (k == K_CLEAR) begin
                    m_mode = 0;
                    m_dig.delete();
                end
            end
        end
        if (fb) begin
            b_start = e; b_len = FAILB; b_fail = 1;
        end else if (kb && !(b_fail && b_len > 0 && e <= b_start + b_len)) begin
            b_start = e; b_len = KEYB; b_fail = 0;
        end
        x.cyc = e;
        if (m_mode == 1)      x.disp = 12'hAAA;
        else if (m_mode == 2) x.disp = 12'h000;
        else begin
            x.disp = 12'hFFF;
            foreach (m_dig[i]) x.disp = {x.disp[7:0], 4'(m_dig[i])};
        end
        x.cnt   = 4'(m_dig.size());
        x.tries = 4'(m_tries);
        x.unl   = (m_mode == 1);
        x.lo    = (m_mode == 2);
        bt      = e - b_start;
        x.buz   = (b_len > 0 && bt >= 0 && bt < b_len) ? ((bt / TONE) % 2 == 0) : 1'b0;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            x = sbq.pop_front();
            compared++;
            mismatched++;
            $display("FAIL stale_expectation: target cycle %0d, now %0d", x.cyc, cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            x = sbq.pop_front();
            check("disp",       32'(disp),       32'(x.disp));
            check("entry_cnt",  32'(entry_cnt),  32'(x.cnt));
            check("tries",      32'(tries),      32'(x.tries));
            check("unlocked",   32'(unlocked),   32'(x.unl));
            check("locked_out", 32'(locked_out), 32'(x.lo));
            check("buzzer",     32'(buzzer),     32'(x.buz));
        end
    end

    task automatic drive(input logic [15:0] k);
        @(negedge clk);
        key_onehot = k;
        model_step(k);
    endtask

    task automatic press(input logic [15:0] k, input int hold);
        repeat (hold) drive(k);
        drive(16'h0);
    endtask

    task automatic enter_code(input int a, input int b, input int c);
        press(dkey(a), 1);
        press(dkey(b), 1);
        press(dkey(c), 1);
        press(K_ENTER, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        key_onehot = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_disp",     32'(disp),       32'h0FFF);
        check("reset_cnt",      32'(entry_cnt),  32'h0);
        check("reset_tries",    32'(tries),      32'h0);
        check("reset_unlocked", 32'(unlocked),   32'h0);
        check("reset_lockout",  32'(locked_out), 32'h0);
        check("reset_buzzer",   32'(buzzer),     32'h0);

        // correct code with the full key beep observed
        enter_code(2, 4, 6);
        idle(KEYB + 5);
        press(K_CLEAR, 1);

        // wrong code, let the fail beep run out, then the right code
        enter_code(1, 1, 1);
        idle(FAILB + 5);
        enter_code(2, 4, 6);
        idle(5);
        press(K_CLEAR, 1);

        // held key gives one entry; fourth digit is ignored
        press(dkey(5), 100);
        press(K_CLEAR, 1);
        idle(KEYB);
        press(dkey(1), 1);
        press(dkey(2), 2);
        press(dkey(3), 1);
        idle(KEYB + 2);
        press(dkey(4), 1);
        idle(3);

        // illegal inputs: two keys at once, ENTER on a partial code
        press(16'h0048, 2);
        press(K_CLEAR, 1);
        press(dkey(2), 1);
        press(dkey(4), 1);
        press(K_ENTER, 1);
        press(16'h0048, 1);
        press(K_CLEAR, 1);

        // lockout, correct code ignored, ADMIN recovers
        for (int n = 0; n < MAX_TRIES; n++) enter_code(1, 1, 1);
        enter_code(2, 4, 6);
        press(K_CLEAR, 1);
        press(K_ADMIN, 1);
        idle(3);

        // asynchronous reset in the middle of a fail beep
        enter_code(7, 7, 7);
        press(dkey(7), 1);
        #2 rst_n = 1'b0;
        key_onehot = '0;
        #1;
        check("async_rst_buzzer", 32'(buzzer),    32'h0);
        check("async_rst_disp",   32'(disp),      32'h0FFF);
        check("async_rst_tries",  32'(tries),     32'h0);
        check("async_rst_cnt",    32'(entry_cnt), 32'h0);
        sbq.delete();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // randomized key traffic
        for (int n = 0; n < 500; n++) begin
            int          r, i, j;
            logic [15:0] k;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                enter_code(2, 4, 6);
            end else begin
                if (r < 55)      k = dkey($urandom_range(0, 9));
                else if (r < 68) k = K_ENTER;
                else if (r < 76) k = K_CLEAR;
                else if (r < 79) k = K_ADMIN;
                else if (r < 89) begin
                    i = $urandom_range(0, 15);
                    j = (i + $urandom_range(1, 15)) % 16;
                    k = (16'h1 << i) | (16'h1 << j);
                end else         k = 16'h1 << $urandom_range(0, 15);
                repeat ($urandom_range(1, 3)) drive(k);
                if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 2)) drive(16'h0);
            end
        end

        idle(FAILB + 5);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
